// File: rtl/conv_window_ctrl.sv
// conv_window_ctrl: sequencing controller for a KW x KH sliding-window
// convolution front end. It accepts a raster-ordered pixel stream, drives the
// window shift-register enable, and flags each complete window together with
// the (row, col) of its bottom-right pixel.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   i_run               single-cycle frame start (honoured only in IDLE)
//   i_width, i_height   frame dimensions, sampled on an accepted i_run
//   s_valid / s_ready   upstream pixel handshake
//   o_shift_en          window shift-register enable (s_valid & s_ready)
//   m_valid / m_ready   downstream window handshake
//   o_col, o_row        bottom-right pixel position of the current window
//   o_idle              controller is idle
//   o_done              one-cycle frame-end pulse
//   o_stall_cnt         downstream stall cycle count
//
// Optional feature: define WINDOW_CTRL_STALL_CNT_EN to build the saturating
// stall counter; otherwise o_stall_cnt is tied to zero.

module conv_window_ctrl #(
  parameter int unsigned KW     = 3,
  parameter int unsigned KH     = 3,
  parameter int unsigned DIM_BW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_run,
  input  logic [DIM_BW-1:0] i_width,
  input  logic [DIM_BW-1:0] i_height,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              o_shift_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DIM_BW-1:0] o_col,
  output logic [DIM_BW-1:0] o_row,
  output logic              o_idle,
  output logic              o_done,
  output logic [31:0]       o_stall_cnt
);

  localparam logic [DIM_BW-1:0] KW_L   = DIM_BW'(KW);
  localparam logic [DIM_BW-1:0] KH_L   = DIM_BW'(KH);
  localparam logic [DIM_BW-1:0] KW_M1  = DIM_BW'(KW - 1);
  localparam logic [DIM_BW-1:0] KH_M1  = DIM_BW'(KH - 1);
  localparam logic [DIM_BW-1:0] ONE    = DIM_BW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DIM_BW-1:0] r_width;
  logic [DIM_BW-1:0] r_height;
  logic [DIM_BW-1:0] r_col;
  logic [DIM_BW-1:0] r_row;
  logic              r_m_valid;
  logic [DIM_BW-1:0] r_o_col;
  logic [DIM_BW-1:0] r_o_row;

  logic w_run_acc;
  logic w_dims_ok;
  logic w_ready;
  logic w_accept;
  logic w_col_last;
  logic w_last_pix;
  logic w_win;

  // Handshake and position decode
  assign w_run_acc  = (r_state == S_IDLE) && i_run;
  assign w_dims_ok  = (i_width >= KW_L) && (i_height >= KH_L);
  assign w_ready    = (r_state == S_RUN) && (!r_m_valid || m_ready);
  assign w_accept   = s_valid && w_ready;
  assign w_col_last = (r_col == (r_width - ONE));
  assign w_last_pix = w_accept && w_col_last && (r_row == (r_height - ONE));
  // A window completes once the pixel lands at or past the kernel's bottom-right corner
  assign w_win      = w_accept && (r_row >= KH_M1) && (r_col >= KW_M1);

  assign s_ready    = w_ready;
  assign o_shift_en = w_accept;
  assign m_valid    = r_m_valid;
  assign o_col      = r_o_col;
  assign o_row      = r_o_row;
  assign o_idle     = (r_state == S_IDLE);
  assign o_done     = (r_state == S_DONE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (i_run) begin
          w_state_nxt = w_dims_ok ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        if (w_last_pix) begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // The final window must be handed off before the frame is declared done
        if (!r_m_valid || m_ready) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Frame geometry and raster position counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_width  <= '0;
      r_height <= '0;
      r_col    <= '0;
      r_row    <= '0;
    end else if (w_run_acc) begin
      r_width  <= i_width;
      r_height <= i_height;
      r_col    <= '0;
      r_row    <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= r_row + ONE;
      end else begin
        r_col <= r_col + ONE;
      end
    end
  end

  // Window output register: one cycle behind the shift register, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid <= 1'b0;
      r_o_col   <= '0;
      r_o_row   <= '0;
    end else if (w_win) begin
      r_m_valid <= 1'b1;
      r_o_col   <= r_col;
      r_o_row   <= r_row;
    end else if (r_m_valid && m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

`ifdef WINDOW_CTRL_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles where a window waits on the downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_run_acc) begin
      r_stall_cnt <= '0;
    end else if (r_m_valid && !m_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_stall_cnt = r_stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Directed self-checking bench for conv_window_ctrl (KW=KH=3, DIM_BW=16).
// Inputs change 1 time unit after the rising edge; a negedge monitor
// accumulates shift pulses, done pulses and accepted windows.

module tb_conv_window_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_run;
  logic [15:0] i_width;
  logic [15:0] i_height;
  logic        s_valid;
  logic        s_ready;
  logic        o_shift_en;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] o_col;
  logic [15:0] o_row;
  logic        o_idle;
  logic        o_done;
  logic [31:0] o_stall_cnt;

  int n_vec;
  int n_err;

  int sh_cnt;
  int dn_cnt;
  int n_win;
  logic [15:0] win_r [64];
  logic [15:0] win_c [64];

  conv_window_ctrl #(.KW(3), .KH(3), .DIM_BW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_run      (i_run),
    .i_width    (i_width),
    .i_height   (i_height),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .o_shift_en (o_shift_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .o_col      (o_col),
    .o_row      (o_row),
    .o_idle     (o_idle),
    .o_done     (o_done),
    .o_stall_cnt(o_stall_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_shift_en) sh_cnt++;
    if (o_done) dn_cnt++;
    if (m_valid && m_ready) begin
      if (n_win < 64) begin
        win_r[n_win] = o_row;
        win_c[n_win] = o_col;
      end
      n_win++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_win(input string tag, input int idx, input int r, input int c);
    chk({tag, "_row"}, 32'(win_r[idx]), 32'(r));
    chk({tag, "_col"}, 32'(win_c[idx]), 32'(c));
  endtask

  task automatic start(input int w, input int h);
    i_run    = 1'b1;
    i_width  = 16'(w);
    i_height = 16'(h);
    @(posedge clk); #1;
    i_run    = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (!o_idle && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk({tag, "_idle_timeout"}, 32'(o_idle), 32'd1);
  endtask

  int b_sh, b_dn, b_w, exp_stall, k;

  initial begin
`ifdef WINDOW_CTRL_STALL_CNT_EN
    exp_stall = 5;
`else
    exp_stall = 0;
`endif
    rst = 1'b1; i_run = 1'b0; i_width = '0; i_height = '0;
    s_valid = 1'b0; m_ready = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset values
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_shift_en", 32'(o_shift_en), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_col", 32'(o_col), 32'd0);
    chk("rst_row", 32'(o_row), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_idle", 32'(o_idle), 32'd1);
    chk("rst_stall", o_stall_cnt, 32'd0);
    rst = 1'b0;

    // 4x4 frame, free-flowing
    s_valid = 1'b1; m_ready = 1'b1;
    b_sh = sh_cnt; b_dn = dn_cnt; b_w = n_win;
    start(4, 4);
    chk("t1_busy", 32'(o_idle), 32'd0);
    wait_idle("t1");
    chk("t1_shifts", 32'(sh_cnt - b_sh), 32'd16);
    chk("t1_windows", 32'(n_win - b_w), 32'd4);
    chk_win("t1_w0", b_w + 0, 2, 2);
    chk_win("t1_w1", b_w + 1, 2, 3);
    chk_win("t1_w2", b_w + 2, 3, 2);
    chk_win("t1_w3", b_w + 3, 3, 3);
    chk("t1_done", 32'(dn_cnt - b_dn), 32'd1);
    chk("t1_stall", o_stall_cnt, 32'd0);

    // 4x4 frame, downstream stalls 5 cycles on the first window
    b_sh = sh_cnt; b_dn = dn_cnt; b_w = n_win;
    start(4, 4);
    k = 0;
    while (!m_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t2_mvalid_timeout", 32'(m_valid), 32'd1);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_s_ready", 32'(s_ready), 32'd0);
      chk("t2_hold_valid", 32'(m_valid), 32'd1);
      chk("t2_hold_row", 32'(o_row), 32'd2);
      chk("t2_hold_col", 32'(o_col), 32'd2);
      @(posedge clk); #1;
    end
    chk("t2_stall_cnt", o_stall_cnt, 32'(exp_stall));
    m_ready = 1'b1;
    wait_idle("t2");
    chk("t2_shifts", 32'(sh_cnt - b_sh), 32'd16);
    chk("t2_windows", 32'(n_win - b_w), 32'd4);
    chk_win("t2_w0", b_w + 0, 2, 2);
    chk_win("t2_w3", b_w + 3, 3, 3);
    chk("t2_done", 32'(dn_cnt - b_dn), 32'd1);
    chk("t2_stall_end", o_stall_cnt, 32'(exp_stall));

    // Undersized frame goes straight to DONE
    b_sh = sh_cnt; b_dn = dn_cnt;
    start(2, 5);
    chk("t3_done_now", 32'(o_done), 32'd1);
    chk("t3_not_idle", 32'(o_idle), 32'd0);
    chk("t3_s_ready", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    chk("t3_done_clear", 32'(o_done), 32'd0);
    chk("t3_idle", 32'(o_idle), 32'd1);
    chk("t3_shifts", 32'(sh_cnt - b_sh), 32'd0);
    chk("t3_done_pulses", 32'(dn_cnt - b_dn), 32'd1);

    // Reset after 7 pixels abandons the frame
    b_sh = sh_cnt; b_dn = dn_cnt;
    start(4, 4);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1; s_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("t4_idle", 32'(o_idle), 32'd1);
    chk("t4_m_valid", 32'(m_valid), 32'd0);
    chk("t4_s_ready", 32'(s_ready), 32'd0);
    chk("t4_row", 32'(o_row), 32'd0);
    chk("t4_col", 32'(o_col), 32'd0);
    chk("t4_stall", o_stall_cnt, 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("t4_shifts", 32'(sh_cnt - b_sh), 32'd7);
    chk("t4_no_done", 32'(dn_cnt - b_dn), 32'd0);

    // Restart after reset begins at (0,0)
    s_valid = 1'b1;
    b_sh = sh_cnt; b_dn = dn_cnt; b_w = n_win;
    start(4, 4);
    wait_idle("t4r");
    chk("t4r_shifts", 32'(sh_cnt - b_sh), 32'd16);
    chk("t4r_windows", 32'(n_win - b_w), 32'd4);
    chk_win("t4r_w0", b_w + 0, 2, 2);
    chk_win("t4r_w2", b_w + 2, 3, 2);
    chk("t4r_done", 32'(dn_cnt - b_dn), 32'd1);

    // i_run during RUN of a 5x3 frame is ignored
    b_sh = sh_cnt; b_dn = dn_cnt; b_w = n_win;
    start(5, 3);
    repeat (4) @(posedge clk);
    #1;
    i_run = 1'b1; i_width = 16'd4; i_height = 16'd4;
    @(posedge clk); #1;
    i_run = 1'b0;
    wait_idle("t5");
    chk("t5_shifts", 32'(sh_cnt - b_sh), 32'd15);
    chk("t5_windows", 32'(n_win - b_w), 32'd3);
    chk_win("t5_w0", b_w + 0, 2, 2);
    chk_win("t5_w1", b_w + 1, 2, 3);
    chk_win("t5_w2", b_w + 2, 2, 4);
    chk("t5_done", 32'(dn_cnt - b_dn), 32'd1);
    repeat (3) @(posedge clk); #1;
    chk("t5_stay_idle", 32'(o_idle), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
